// File: rtl/nes_dma_engine_if.sv
// CPU-side bus bundle shared by the DMA engine and the surrounding system.
// The master modport is the DMA engine; the slave is the system bus/CPU side.
interface nes_dma_engine_if;
  logic [15:0] addr_in;
  logic [7:0]  rdata;
  logic [15:0] addr_out;
  logic [7:0]  wdata;
  logic        rd;
  logic        wr;
  logic        cpu_stall;

  modport master (
    input  addr_in, rdata,
    output addr_out, wdata, rd, wr, cpu_stall
  );

  modport slave (
    output addr_in, rdata,
    input  addr_out, wdata, rd, wr, cpu_stall
  );
endinterface

// File: rtl/nes_dma_engine.sv
// Multi-channel NES-style page DMA: halts the CPU, copies a 256-byte page
// (or fewer bytes) read/write pairwise, with optional odd-cycle alignment.
module nes_dma_engine #(
  parameter int NUM_CH    = 2,
  parameter int ALIGN_ODD = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_CH-1:0]    trig,
  input  logic [NUM_CH*8-1:0]  src_page,
  input  logic [NUM_CH*16-1:0] dst_addr,
  input  logic [NUM_CH-1:0]    dst_inc,
  input  logic [NUM_CH*9-1:0]  len,
  nes_dma_engine_if.master     bus,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        state, state_n;
  logic              parity;
  logic [NUM_CH-1:0] pending, pend_set, pend_clr;
  logic [CH_W-1:0]   cur_ch, sel_ch;
  logic              sel_valid, sel_load;
  logic [7:0]        page, idx;
  logic [15:0]       dst;
  logic              inc;
  logic [8:0]        remaining, sel_len, len_eff;
  logic [7:0]        wdata_q;
  logic              active;
  logic [NUM_CH-1:0] cur_onehot;

  // Lowest-index pending channel wins; the descending loop leaves it last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel_ch    = CH_W'(i);
      end
    end
  end

  assign sel_load = sel_valid && (state == IDLE || state == DONE);
  assign sel_len  = len[sel_ch*9 +: 9];
  assign len_eff  = (sel_len == 9'd0 || sel_len > 9'd256) ? 9'd256 : sel_len;
  assign pend_set = trig & ~pending;
  assign pend_clr = sel_load ? (NUM_CH'(1) << sel_ch) : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sel_valid) state_n = HALT;
      HALT:    state_n = (ALIGN_ODD != 0 && parity) ? ALIGN : READ;
      ALIGN:   state_n = READ;
      READ:    state_n = WRITE;
      WRITE:   state_n = (remaining == 9'd1) ? DONE : READ;
      DONE:    state_n = sel_valid ? HALT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      parity    <= 1'b0;
      pending   <= '0;
      cur_ch    <= '0;
      page      <= '0;
      idx       <= '0;
      dst       <= '0;
      inc       <= 1'b0;
      remaining <= '0;
      wdata_q   <= '0;
    end else begin
      state   <= state_n;
      parity  <= ~parity;
      pending <= (pending & ~pend_clr) | pend_set;
      if (sel_load) begin
        cur_ch    <= sel_ch;
        page      <= src_page[sel_ch*8 +: 8];
        dst       <= dst_addr[sel_ch*16 +: 16];
        inc       <= dst_inc[sel_ch];
        remaining <= len_eff;
        idx       <= '0;
      end
      if (state == READ) wdata_q <= bus.rdata;
      if (state == WRITE) begin
        idx       <= idx + 8'd1;
        remaining <= remaining - 9'd1;
        if (inc) dst <= dst + 16'd1;
      end
    end
  end

  assign active     = (state == HALT) || (state == ALIGN) ||
                      (state == READ) || (state == WRITE);
  assign cur_onehot = NUM_CH'(1) << cur_ch;

  assign bus.cpu_stall = active;
  assign bus.rd        = (state == READ);
  assign bus.wr        = (state == WRITE);
  assign bus.wdata     = wdata_q;
  assign bus.addr_out  = (state == READ)  ? {page, idx} :
                         (state == WRITE) ? dst : bus.addr_in;

  assign busy = pending | (active ? cur_onehot : '0);
  assign done = (state == DONE) ? cur_onehot : '0;

endmodule
